icache_direct: RTL and testbench
================================

// Module: icache_direct
// PURPOSE
//  Direct-mapped, one-word-per-frame, read-only instruction cache between the pipeline
//  fetch port (imemREN/imemaddr -> ihit/imemload) and the memory controller instruction port.
//  Hits return in the same cycle. Misses stall the pipeline: ihit stays low until the frame fills.
//  Also keeps saturating hit and miss counters for performance measurement.
// PARAMETERS
//  NSETS   16  number of frames; power of 2, >= 2
//  IDX_W   4   $clog2(NSETS); index = imemaddr[IDX_W+1:2], tag = imemaddr[31:IDX_W+2]
// PORTS
//  CLK        in   1         clock; all state updates on posedge
//  RST        in   1         synchronous reset, active-high
//  imemREN    in   1         fetch request from pipeline
//  imemaddr   in   32        fetch byte address; bits [1:0] ignored
//  ihit       out  1         fetch data valid this cycle
//  imemload   out  32        fetched instruction word
//  iREN       out  1         read request to memory
//  iaddr      out  32        memory read address, {imemaddr[31:2],2'b00}
//  iwait      in   1         memory busy; iload is valid in the cycle iwait==0 while iREN==1
//  iload      in   32        memory read data
//  flush      in   1         invalidate all frames
//  hit_count  out  32        cycles with ihit==1, saturates at 32'hFFFFFFFF
//  miss_count out  32        IDLE->MISS transitions, saturates at 32'hFFFFFFFF
// BEHAVIOUR
//  Reset (RST==1 at posedge):
//   - all valid bits cleared, state=IDLE, both counters=0.
//   - While RST is high: ihit=0, iREN=0, imemload=0.
//   - Tag/data arrays are not reset.
//  FSM states: IDLE, MISS.
//  IDLE:
//   - hit = imemREN & valid[idx] & (tag[idx]==addr tag).
//   - On hit: ihit=1 and imemload=data[idx] combinationally, same cycle.
//   - On imemREN & !hit: ihit=0; next state MISS; miss_count+1.
//   - iREN=0 in IDLE.
//  MISS:
//   - iREN=1, iaddr = current imemaddr, ihit=0, imemload=0.
//   - When iwait==0: write data[idx]=iload and tag[idx]=addr tag, set valid[idx]=1, go to IDLE.
//     The following cycle hits, so a miss costs (memory latency + 1) cycles of ihit==0.
//   - imemREN==0 (request withdrawn): go to IDLE next cycle, no fill, even if iwait==0.
//  Address stability:
//   - The pipeline holds imemaddr while ihit==0.
//   - If imemaddr still changes during MISS, the fill uses the address present in the
//     iwait==0 cycle. Tag and data are always written consistently.
//  Flush:
//   - flush at posedge clears every valid bit and forces state=IDLE.
//   - flush wins over a simultaneous fill: the frame is left invalid.
//   - ihit is forced to 0 in any cycle where flush==1.
//  Conflicts:
//   - Two addresses with the same index evict each other; there is no replacement choice.
//  Counters:
//   - hit_count increments in each cycle with ihit==1.
//   - Both counters hold at all-ones; they do not wrap.
//  No write path: instruction memory is read-only through this block.
// TESTING
//  1. Cold read: reset, then imemREN=1 at 0x00000040 with 2-cycle iwait.
//     -> ihit=0 for 3 cycles, then ihit=1 with imemload=memory word; miss_count=1.
//  2. Hit: re-fetch 0x40 the next cycle -> ihit=1 same cycle, no iREN, hit_count increments.
//  3. Conflict (NSETS=16): fetch 0x40, then 0x80, then 0x40.
//     -> both share index 0; the third fetch misses again; miss_count=3.
//  4. Flush during a fill: in MISS, drive iwait=0 together with flush=1.
//     -> valid stays 0, state=IDLE, the next fetch of that address misses.
//  5. Withdraw: imemREN drops mid-MISS.
//     -> iREN=0 next cycle, frame not written, no ihit.
//  6. Reset mid-MISS: assert RST while iREN=1.
//     -> next cycle iREN=0, counters=0, all previously cached addresses miss.
//     Also preload hit_count=32'hFFFFFFFF and check it holds on a further hit.

Source files
------------

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-frame, read-only instruction cache with
// same-cycle hits, a two-state miss FSM and saturating hit/miss counters.
module icache_direct #(
  parameter int NSETS = 16,
  parameter int IDX_W = $clog2(NSETS)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  input  logic        flush,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, MISS} state_t;

  state_t           state;
  logic [NSETS-1:0] valid;
  logic [TAG_W-1:0] tags [NSETS];
  logic [31:0]      data [NSETS];
  logic [31:0]      hit_cnt, miss_cnt;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit, fill;
  logic             unused_low;

  assign idx        = imemaddr[IDX_W+1:2];
  assign tag        = imemaddr[31:IDX_W+2];
  assign unused_low = ^imemaddr[1:0];

  assign hit  = imemREN & valid[idx] & (tags[idx] == tag);
  // Fill uses whatever address is on the port in the iwait==0 cycle, so tag
  // and data always land in the same frame together.
  assign fill = (state == MISS) & imemREN & ~iwait & ~RST;

  assign ihit       = ~RST & ~flush & (state == IDLE) & hit;
  assign imemload   = ihit ? data[idx] : 32'd0;
  assign iREN       = ~RST & (state == MISS);
  assign iaddr      = {imemaddr[31:2], 2'b00};
  assign hit_count  = hit_cnt;
  assign miss_count = miss_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      valid    <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (ihit && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      if (flush) begin
        // Flush beats a simultaneous fill; the frame stays invalid.
        valid <= '0;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (imemREN && !hit) begin
            state <= MISS;
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
          end
          MISS: if (!imemREN) begin
            state <= IDLE;
          end else if (!iwait) begin
            valid[idx] <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Tag/data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tags[idx] <= tag;
      data[idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: the bench plays the memory controller,
// queues the word each fetch should return and checks it when ihit fires.
module tb_icache_direct;
  logic        CLK = 1'b0, RST = 1'b1, imemREN = 1'b0, iwait = 1'b1, flush = 1'b0;
  logic [31:0] imemaddr = '0, iload = '0;
  logic        ihit, iREN;
  logic [31:0] imemload, iaddr, hit_count, miss_count;

  int          n_cmp = 0, n_err = 0;
  int          st;
  logic [31:0] exp_q [$];

  always #5 CLK = ~CLK;

  icache_direct #(.NSETS(16), .IDX_W(4)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .flush(flush),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a negedge. lat = number of MISS cycles (iwait low in the last).
  task automatic fetch(input logic [31:0] a, input int lat, output int stall);
    int   waited;
    logic done;
    waited = 0; done = 1'b0; stall = 0;
    exp_q.push_back(mem(a));
    imemREN = 1'b1; imemaddr = a;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (ihit) begin
        chk("hit_data", imemload, exp_q.pop_front());
        chk("hit_iren", {31'b0, iREN}, 32'd0);
        done = 1'b1;
      end else begin
        stall++;
        if (iREN) begin
          chk("iaddr", iaddr, {a[31:2], 2'b00});
          iwait  = (waited < lat - 1);
          iload  = mem(iaddr);
          waited++;
        end
      end
      @(negedge CLK);
    end
    if (!done) begin
      chk("fetch_timeout", {31'b0, ihit}, 32'd1);
      void'(exp_q.pop_back());
    end
    imemREN = 1'b0; iwait = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset, with a request pending to prove outputs stay quiet
    imemREN = 1'b1; imemaddr = 32'h40;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_ihit", {31'b0, ihit}, 32'd0);
    chk("rst_iren", {31'b0, iREN}, 32'd0);
    chk("rst_load", imemload, 32'd0);
    RST = 1'b0; imemREN = 1'b0;
    @(negedge CLK); #1;
    chk("rst_hitcnt", hit_count, 32'd0);
    chk("rst_misscnt", miss_count, 32'd0);
    chk("rst_idle_iren", {31'b0, iREN}, 32'd0);
    @(negedge CLK);

    // Cold read, then hit (byte offset ignored)
    fetch(32'h40, 2, st); chk("cold_stall", st, 32'd3);
    chk("cold_miss", miss_count, 32'd1);
    chk("cold_hitcnt", hit_count, 32'd1);
    fetch(32'h43, 2, st); chk("hit_stall", st, 32'd0);
    chk("hit_hitcnt", hit_count, 32'd2);
    chk("hit_miss", miss_count, 32'd1);

    // Conflict on index 0, then a different index does not evict
    fetch(32'h80, 4, st); chk("conf80_stall", st, 32'd5);
    fetch(32'h40, 1, st); chk("conf40_stall", st, 32'd2);
    chk("conf_miss", miss_count, 32'd3);
    fetch(32'h44, 3, st); chk("idx1_stall", st, 32'd4);
    fetch(32'h40, 2, st); chk("idx0_kept", st, 32'd0);
    chk("conf_hitcnt", hit_count, 32'd6);

    // Flush gates a would-be hit, then flush during a fill
    imemREN = 1'b1; imemaddr = 32'h40; flush = 1'b1;
    #1 chk("flush_ihit", {31'b0, ihit}, 32'd0);
    @(negedge CLK);
    flush = 1'b0; imemaddr = 32'h48;
    #1 chk("f48_miss", {31'b0, ihit}, 32'd0);
    @(negedge CLK); #1;
    chk("f48_iren", {31'b0, iREN}, 32'd1);
    iwait = 1'b0; iload = mem(32'h48); flush = 1'b1;
    #1 chk("ffill_ihit", {31'b0, ihit}, 32'd0);
    @(negedge CLK);
    flush = 1'b0; iwait = 1'b1; imemREN = 1'b0;
    #1 chk("ffill_idle", {31'b0, iREN}, 32'd0);
    @(negedge CLK);
    fetch(32'h48, 2, st); chk("ffill_refetch", st, 32'd3);
    fetch(32'h40, 1, st); chk("flush_evict40", st, 32'd2);
    chk("flush_miss", miss_count, 32'd7);
    chk("flush_hitcnt", hit_count, 32'd8);

    // Withdraw mid-MISS while memory answers: no fill
    imemREN = 1'b1; imemaddr = 32'h4C;
    #1 chk("wd_miss", {31'b0, ihit}, 32'd0);
    @(negedge CLK); #1;
    chk("wd_iren", {31'b0, iREN}, 32'd1);
    imemREN = 1'b0; iwait = 1'b0; iload = mem(32'h4C);
    #1 chk("wd_ihit", {31'b0, ihit}, 32'd0);
    @(negedge CLK);
    iwait = 1'b1;
    #1 chk("wd_iren_off", {31'b0, iREN}, 32'd0);
    chk("wd_ihit2", {31'b0, ihit}, 32'd0);
    @(negedge CLK);
    fetch(32'h4C, 2, st); chk("wd_refetch", st, 32'd3);
    chk("wd_miss_cnt", miss_count, 32'd9);

    // Reset mid-MISS
    imemREN = 1'b1; imemaddr = 32'h50;
    @(negedge CLK); #1;
    chk("rm_iren", {31'b0, iREN}, 32'd1);
    RST = 1'b1;
    #1 chk("rm_iren_rst", {31'b0, iREN}, 32'd0);
    chk("rm_load_rst", imemload, 32'd0);
    @(negedge CLK);
    RST = 1'b0; imemREN = 1'b0;
    #1 chk("rm_iren_after", {31'b0, iREN}, 32'd0);
    chk("rm_hitcnt", hit_count, 32'd0);
    chk("rm_misscnt", miss_count, 32'd0);
    @(negedge CLK);
    fetch(32'h40, 2, st); chk("rm_40_miss", st, 32'd3);
    fetch(32'h44, 3, st); chk("rm_44_miss", st, 32'd4);
    chk("rm_miss2", miss_count, 32'd2);

    // Hit counter saturation
    force dut.hit_cnt = 32'hFFFFFFFE;
    #1 release dut.hit_cnt;
    chk("sat_preload", hit_count, 32'hFFFFFFFE);
    fetch(32'h40, 2, st); chk("sat_hit1", st, 32'd0);
    chk("sat_reach", hit_count, 32'hFFFFFFFF);
    fetch(32'h44, 2, st); chk("sat_hit2", st, 32'd0);
    chk("sat_hold", hit_count, 32'hFFFFFFFF);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
